pool_exec_param: RTL and testbench
==================================

// Module: pool_exec_param
// PURPOSE
//   Parametrised multi-channel pooling engine: CH parallel lanes, each reducing WIN consecutive
//   accepted samples to one result by max or average (runtime-selectable). Sits between a conv
//   feature-map read port and the next layer's write port; replaces the fixed 16-lane max-only
//   pool array. Adds valid/ready flow control, a one-entry output buffer and window abort.
// PARAMETERS
//   CH   16  number of parallel channels (lanes)
//   DW   16  sample width, two's-complement fixed point
//   WIN  4   samples per pooling window (2x2 = 4); must be a power of two, 2..16
// PORTS
//   clk        in   1       clock, all logic rising-edge
//   rst        in   1       synchronous reset, active-high
//   pool_mode  in   1       0 = max, 1 = average; sampled on the first beat of each window
//   pool_clr   in   1       abort the current partial window
//   in_valid   in   1       in_data holds one sample per lane
//   in_ready   out  1       block accepts in_data this cycle
//   in_data    in   CH*DW   lane k at [k*DW +: DW]
//   out_valid  out  1       out_data holds a completed window result
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  CH*DW   lane k result at [k*DW +: DW]
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): cnt=0, out_valid=0, out_data=0, in_ready=0 that cycle,
//     latched mode=0, all lane registers=0. Reset mid-window discards the partial window and any
//     pending output.
//   - Beat accepted when in_valid && in_ready. in_ready = !rst && !pool_clr &&
//     !(cnt==WIN-1 && out_valid && !out_ready). Only the completing beat stalls on a full buffer.
//   - cnt counts accepted beats, 0..WIN-1, clog2(WIN) bits. On accept: cnt=WIN-1 wraps to 0,
//     else cnt+1.
//   - Beat with cnt==0: latch pool_mode into mode_q. Per lane, load max_q=sample, acc_q=sample
//     sign-extended to DW+clog2(WIN) bits.
//   - Beat with cnt 1..WIN-2: max_q=max(max_q,sample) (signed compare), acc_q+=sample.
//     pool_mode changes mid-window are ignored.
//   - Beat with cnt==WIN-1 (completing): result uses this beat's sample, combinationally
//     folded in. max: signed max. avg: (acc_q+sample) >>> clog2(WIN), arithmetic, truncation
//     toward -inf, low DW bits. The adder cannot overflow.
//     out_data<=result, out_valid<=1 on the same edge. Latency: the result is visible the cycle
//     after the last beat is accepted.
//   - Output buffer: out_valid clears when out_ready && out_valid and no completion happens on
//     the same edge. If out_ready is high and a completion happens on the same edge, the new
//     result overwrites and out_valid stays 1 (back-to-back, no bubble). out_data stays stable
//     while out_valid && !out_ready.
//   - pool_clr=1: cnt<=0, no beat accepted (clr beats in_valid). The pending output is kept.
//     rst has priority over pool_clr.
//   - With WIN=1 every accepted beat completes. This is not supported; the parameter check
//     rejects it.
//   - All lanes share cnt and mode_q and advance in lock-step. No per-lane enable.
// TESTING
//   1. CH=2, WIN=4, max. Lane0 beats 3,-7,12,5 -> out lane0=12 one cycle after beat 4, out_valid=1.
//   2. avg, lane0 beats -1,-2,-2,-2 -> sum=-7, out=-2 (>>>2 rounds toward -inf). Beats 4,4,4,5 -> 4.
//   3. out_ready=0 with a result pending. Beats 1-3 of the next window are accepted; beat 4 sees
//      in_ready=0 and out_data is unchanged. Raise out_ready -> beat 4 is accepted, the new result
//      follows and no result is lost.
//   4. Two beats accepted, then pool_clr=1 with in_valid=1 -> beat rejected, cnt=0. The next 4
//      beats form a fresh window, and the old partial samples are absent from the result.
//   5. pool_mode toggled after beat 1 of a window -> the result uses the mode from beat 1.
//      rst asserted after beat 3 -> out_valid=0, out_data=0, cnt=0.
//   6. Continuous in_valid with out_ready=1 over 8 windows -> a result every 4 cycles,
//      in_ready never drops.

Source files
------------

// File: rtl/pool_exec_param.sv
// ---------------------------------------------------------------------------
// pool_exec_param
//   Multi-channel pooling engine. CH lanes run in lock-step; each reduces WIN
//   consecutive accepted samples to one result, either the signed maximum or
//   the floor-average (sum >>> log2(WIN)). The reduction mode is captured on
//   the first beat of each window. A one-entry output buffer with valid/ready
//   lets a result wait for downstream while the next window fills. Only the
//   completing beat of a window stalls when that buffer is still occupied.
//
// Parameters
//   CH   number of lanes
//   DW   sample width (two's complement)
//   WIN  samples per window, power of two in 2..16
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   pool_mode  0 = max, 1 = average (sampled on the first beat of a window)
//   pool_clr   abort the current partial window (pending output is kept)
//   in_valid   in_data carries one sample per lane
//   in_ready   beat is accepted this cycle when in_valid is also high
//   in_data    lane k at [k*DW +: DW]
//   out_valid  out_data holds a completed window result
//   out_ready  downstream takes out_data this cycle
//   out_data   lane k result at [k*DW +: DW]
// ---------------------------------------------------------------------------
module pool_exec_param #(
  parameter int CH  = 16,
  parameter int DW  = 16,
  parameter int WIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pool_mode,
  input  logic             pool_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int AW = DW + CW;
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  if (WIN < 2 || WIN > 16 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("pool_exec_param: WIN must be a power of two in 2..16");
  end

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] s);
    return {{CW{s[DW-1]}}, s};
  endfunction

  // Arithmetic shift floors toward -inf; the sum of WIN samples shifted by
  // log2(WIN) always fits back into DW bits.
  function automatic logic signed [DW-1:0] avg_floor(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] sh;
    sh = s >>> CW;
    return sh[DW-1:0];
  endfunction

  logic [CW-1:0]    cnt_p0;
  logic             mode_p0;
  logic [CH*DW-1:0] res_data;
  logic             last_beat;
  logic             accept;
  logic             complete;

  assign last_beat = (cnt_p0 == LAST);
  assign in_ready  = !rst && !pool_clr && !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && last_beat;

  // Stage p0: per-lane running max / sum, result folds in the completing beat
  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic signed [DW-1:0] samp;
    logic signed [DW-1:0] max_p0;
    logic signed [AW-1:0] acc_p0;
    logic signed [AW-1:0] sum;

    assign samp = in_data[k*DW +: DW];
    assign sum  = acc_p0 + sext(samp);
    assign res_data[k*DW +: DW] = mode_p0 ? avg_floor(sum) : smax(max_p0, samp);

    always_ff @(posedge clk) begin
      if (rst) begin
        max_p0 <= '0;
        acc_p0 <= '0;
      end else if (accept && !last_beat) begin
        if (cnt_p0 == '0) begin
          max_p0 <= samp;
          acc_p0 <= sext(samp);
        end else begin
          max_p0 <= smax(max_p0, samp);
          acc_p0 <= sum;
        end
      end
    end
  end

  // Shared window control: beat counter and latched mode
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      mode_p0 <= 1'b0;
    end else if (pool_clr) begin
      cnt_p0 <= '0;
    end else if (accept) begin
      cnt_p0 <= last_beat ? '0 : cnt_p0 + 1'b1;
      if (cnt_p0 == '0) mode_p0 <= pool_mode;
    end
  end

  // Stage p1: one-entry output buffer; a completion on the same edge as a
  // downstream take overwrites without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_exec_param.sv
module tb_pool_exec_param;

  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int WIN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pool_mode;
  logic             pool_clr;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;

  int n_vec  = 0;
  int n_fail = 0;
  int stalls = 0;
  logic [31:0] exp_q[$];

  pool_exec_param #(.CH(CH), .DW(DW), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .pool_mode(pool_mode), .pool_clr(pool_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int l0, input int l1);
    logic [31:0] a;
    logic [31:0] b;
    a = l0;
    b = l1;
    return {b[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output transfer pops one expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL out_unexpected: got %h, expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Present one beat and hold it until accepted (bounded wait)
  task automatic beat(input int a, input int b);
    int n;
    logic [31:0] d;
    d = pk(a, b);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL beat_timeout: in_ready=%b, expected 1", in_ready);
    end
    stalls += n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pool_mode = 1'b0; pool_clr = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);

    // 1: max, latency one cycle after the last beat
    pool_mode = 1'b0;
    beat(3, -5); beat(-7, -3); beat(12, -9);
    exp_q.push_back(pk(12, -3));
    beat(5, -4);
    check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    check("t1_latency_data", out_data, pk(12, -3));
    idle(2);

    // 2: average, floor toward -inf, and extremes
    pool_mode = 1'b1;
    beat(-1, 4); beat(-2, 4); beat(-2, 4);
    exp_q.push_back(pk(-2, 4));
    beat(-2, 5);
    beat(4, -1); beat(4, -2); beat(4, -2);
    exp_q.push_back(pk(4, -2));
    beat(5, -2);
    beat(32767, -32768); beat(32767, -32768); beat(32767, -32768);
    exp_q.push_back(pk(32767, -32768));
    beat(32767, -32768);
    pool_mode = 1'b0;
    beat(-32768, 32767); beat(-32768, 0); beat(-32768, -1);
    exp_q.push_back(pk(-32767, 32767));
    beat(-32767, -32768);
    idle(2);

    // 3: downstream stall holds the completing beat only
    out_ready = 1'b0;
    beat(1, 10); beat(2, 20); beat(3, 30);
    exp_q.push_back(pk(4, 40));
    beat(4, 40);
    beat(9, -1); beat(8, -1); beat(7, -1);
    in_data  = pk(6, -1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_stall_hold", out_data, pk(4, 40));
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pk(9, -1));
    out_ready = 1'b1;
    beat(6, -1);
    idle(2);

    // 4: pool_clr aborts a partial window and rejects its beat
    beat(100, 100); beat(100, 100);
    pool_clr = 1'b1;
    in_data  = pk(50, 50);
    in_valid = 1'b1;
    @(negedge clk);
    check("t4_clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    pool_clr = 1'b0;
    beat(1, -10); beat(2, -20); beat(3, -30);
    exp_q.push_back(pk(3, -10));
    beat(-4, -40);
    idle(2);

    // 5: mode fixed on the first beat; reset discards a partial window
    pool_mode = 1'b0;
    beat(8, -1);
    pool_mode = 1'b1;
    beat(0, -9); beat(0, -9);
    exp_q.push_back(pk(8, -1));
    beat(0, -9);
    idle(2);
    pool_mode = 1'b0;
    beat(500, 500); beat(500, 500); beat(500, 500);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    beat(7, 1); beat(7, 2); beat(7, 3);
    exp_q.push_back(pk(7, 4));
    beat(7, 4);
    idle(2);

    // 6: eight back-to-back windows, in_ready never drops
    pool_mode = 1'b0;
    stalls = 0;
    for (int w = 0; w < 8; w++) begin
      beat(w, -w - 3); beat(w + 1, -w - 2); beat(w + 2, -w - 1);
      exp_q.push_back(pk(w + 3, -w));
      beat(w + 3, -w);
    end
    check("t6_no_stall", stalls, 32'd0);
    idle(4);

    check("drain_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
